maze_mem_arbiter: RTL and testbench
===================================

MAZE_MEM_ARBITER -- requirements
Module: maze_mem_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising edge), rst input 1 (active-low, asynchronous).
REQ-002 SHALL have solver port: sol_req in 1, sol_wr in 1 (1=write), sol_x in 4, sol_y in 4, sol_din in 1, sol_gnt out 1, sol_vld out 1, sol_dout out 1.
REQ-003 SHALL have host port: host_req in 1, host_wr in 1, host_x in 4, host_y in 4, host_din in 1, host_gnt out 1, host_vld out 1, host_dout out 1.
REQ-004 SHALL have memory port: mem_rd out 1, mem_wr out 1, mem_x out 4, mem_y out 4, mem_din out 1, mem_dout in 1 (valid the cycle after mem_rd).
REQ-005 SHALL have status: busy out 1 (state != IDLE), last_host out 1 (round-robin pointer; 1 = host served last).

Function
REQ-006 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction per 3 cycles.
REQ-007 IDLE: if sol_req or host_req, select winner, register its gnt, wr, x, y, din; go to ACCESS; else stay.
REQ-008 ACCESS: drive mem_x/mem_y/mem_din from captured command; mem_rd = ~wr, mem_wr = wr, for exactly this one cycle.
REQ-009 RESP: pulse winner's vld for one cycle; on a read, register mem_dout into winner's dout at the same edge vld rises.
REQ-010 Write transactions SHALL pulse vld as acknowledge; dout SHALL hold its previous value.
REQ-011 gnt SHALL be high from the cycle after selection through the RESP cycle inclusive; never both gnt high.
REQ-012 Requester command inputs SHALL be sampled only in IDLE; later changes do not affect the in-flight access.
REQ-013 A req dropped after grant SHALL NOT abort the access; vld still pulses.
REQ-014 A req still high after its own vld SHALL be treated as a new request in the following IDLE.
REQ-015 Addresses use full 4-bit range (0..15); no wrap or clamp.
REQ-016 mem_rd and mem_wr SHALL be 0 in IDLE and RESP.
REQ-017 last_host SHALL update in IDLE on selection: 1 if host won, 0 if solver won.

Reset
REQ-018 rst low SHALL asynchronously force state IDLE and all outputs 0 (gnt, vld, dout, mem strobes, mem_x/y/din, busy, last_host).
REQ-019 Reset asserted mid-transaction SHALL drop the access with no vld; memory strobes low immediately.
REQ-020 After rst release, the first arbitration SHALL occur on the first rising edge with a request.

Configuration
REQ-021 Macro ARB_RR_EN defined: on simultaneous requests, winner = solver if last_host=1, else host.
REQ-022 ARB_RR_EN undefined: solver always wins a tie; last_host still tracks the winner.

Verification
REQ-023 Solver read alone: sol_req=1, wr=0, x=3, y=5, mem_dout=1 -> mem_rd high 1 cycle, mem_x=3, mem_y=5, sol_vld at cycle 3, sol_dout=1.
REQ-024 Host write: host_req=1, wr=1, x=15, y=0, din=1 -> mem_wr 1 cycle, mem_din=1, host_vld pulse, host_dout unchanged.
REQ-025 Simultaneous requests held 4 transactions, ARB_RR_EN defined, after reset -> order host, solver, host, solver; undefined -> solver x4.
REQ-026 sol_x changed 5 -> 9 during ACCESS -> mem_x stays 5.
REQ-027 rst low during ACCESS -> mem_rd/mem_wr/gnt drop immediately, no vld; after release, held request served normally.
REQ-028 sol_req dropped in ACCESS -> sol_vld still pulses in RESP; FSM returns IDLE, busy=0.

Source files
------------

// File: rtl/maze_mem_arbiter.sv
// Two-port (solver/host) arbiter onto a single-cell maze memory, 3-cycle transactions.
// Define ARB_RR_EN to resolve simultaneous requests round-robin instead of solver-first.
module maze_mem_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       sol_req,
    input  logic       sol_wr,
    input  logic [3:0] sol_x,
    input  logic [3:0] sol_y,
    input  logic       sol_din,
    output logic       sol_gnt,
    output logic       sol_vld,
    output logic       sol_dout,
    input  logic       host_req,
    input  logic       host_wr,
    input  logic [3:0] host_x,
    input  logic [3:0] host_y,
    input  logic       host_din,
    output logic       host_gnt,
    output logic       host_vld,
    output logic       host_dout,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [3:0] mem_x,
    output logic [3:0] mem_y,
    output logic       mem_din,
    input  logic       mem_dout,
    output logic       busy,
    output logic       last_host
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_host;
    logic       r_wr;
    logic [3:0] r_x;
    logic [3:0] r_y;
    logic       r_din;
    logic       r_last_host;
    logic       r_sol_dout;
    logic       r_host_dout;
    logic       w_any;
    logic       w_pick_host;
    logic       w_acc;
    logic       w_resp;

    assign w_any = sol_req | host_req;

`ifdef ARB_RR_EN
    // On a tie, serve whichever side did not win last time.
    assign w_pick_host = host_req & (~sol_req | ~r_last_host);
`else
    assign w_pick_host = host_req & ~sol_req;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_next = ACCESS;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_host      <= 1'b0;
            r_wr        <= 1'b0;
            r_x         <= 4'd0;
            r_y         <= 4'd0;
            r_din       <= 1'b0;
            r_last_host <= 1'b0;
        end else if (r_state == IDLE && w_any) begin
            r_host      <= w_pick_host;
            r_wr        <= w_pick_host ? host_wr  : sol_wr;
            r_x         <= w_pick_host ? host_x   : sol_x;
            r_y         <= w_pick_host ? host_y   : sol_y;
            r_din       <= w_pick_host ? host_din : sol_din;
            r_last_host <= w_pick_host;
        end
    end

    // Read data is captured on the edge that opens RESP, alongside vld.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sol_dout  <= 1'b0;
            r_host_dout <= 1'b0;
        end else if (r_state == ACCESS && !r_wr) begin
            if (r_host) begin
                r_host_dout <= mem_dout;
            end else begin
                r_sol_dout  <= mem_dout;
            end
        end
    end

    assign w_acc     = (r_state == ACCESS);
    assign w_resp    = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign last_host = r_last_host;

    assign sol_gnt   = busy & ~r_host;
    assign host_gnt  = busy &  r_host;
    assign sol_vld   = w_resp & ~r_host;
    assign host_vld  = w_resp &  r_host;
    assign sol_dout  = r_sol_dout;
    assign host_dout = r_host_dout;

    assign mem_rd    = w_acc & ~r_wr;
    assign mem_wr    = w_acc &  r_wr;
    assign mem_x     = w_acc ? r_x : 4'd0;
    assign mem_y     = w_acc ? r_y : 4'd0;
    assign mem_din   = w_acc & r_din;

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Randomized + directed bench for maze_mem_arbiter against a transaction-level model.
// Honors ARB_RR_EN the same way as the design build.
module tb_maze_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       sol_req, sol_wr, sol_din;
    logic [3:0] sol_x, sol_y;
    logic       sol_gnt, sol_vld, sol_dout;
    logic       host_req, host_wr, host_din;
    logic [3:0] host_x, host_y;
    logic       host_gnt, host_vld, host_dout;
    logic       mem_rd, mem_wr, mem_din, mem_dout;
    logic [3:0] mem_x, mem_y;
    logic       busy, last_host;

    logic [255:0] env_mem;
    logic [255:0] init_mem;
    logic         load;

    logic [255:0] m_mem;
    logic         m_last;
    logic         m_sdout;
    logic         m_hdout;

    int n_vec = 0;
    int n_bad = 0;

    maze_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .sol_req(sol_req), .sol_wr(sol_wr), .sol_x(sol_x), .sol_y(sol_y),
        .sol_din(sol_din), .sol_gnt(sol_gnt), .sol_vld(sol_vld),
        .sol_dout(sol_dout),
        .host_req(host_req), .host_wr(host_wr), .host_x(host_x),
        .host_y(host_y), .host_din(host_din), .host_gnt(host_gnt),
        .host_vld(host_vld), .host_dout(host_dout),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_x(mem_x), .mem_y(mem_y),
        .mem_din(mem_din), .mem_dout(mem_dout),
        .busy(busy), .last_host(last_host)
    );

    always #5 clk = ~clk;

    // Environment memory: reads are combinational, writes land on the clock.
    assign mem_dout = env_mem[{mem_y, mem_x}];
    always @(posedge clk) begin
        if (load) env_mem <= init_mem;
        else if (mem_wr) env_mem[{mem_y, mem_x}] <= mem_din;
    end

    task automatic chk1(input string tag, input logic o, input logic e);
        n_vec++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] o,
                        input logic [3:0] e);
        n_vec++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    // mode 0: plain, 1: scramble commands during ACCESS, 2: drop reqs in ACCESS
    task automatic txn(input logic sr, input logic sw, input logic [3:0] sx,
                       input logic [3:0] sy, input logic sd,
                       input logic hr, input logic hw, input logic [3:0] hx,
                       input logic [3:0] hy, input logic hd, input int mode);
        logic       hwin, wr, din;
        logic [3:0] x, y;
        sol_req = sr;  sol_wr = sw;  sol_x = sx;  sol_y = sy;  sol_din = sd;
        host_req = hr; host_wr = hw; host_x = hx; host_y = hy; host_din = hd;
`ifdef ARB_RR_EN
        hwin = (sr && hr) ? !m_last : hr;
`else
        hwin = hr && !sr;
`endif
        wr  = hwin ? hw : sw;
        x   = hwin ? hx : sx;
        y   = hwin ? hy : sy;
        din = hwin ? hd : sd;

        @(negedge clk);
        chk1("acc_busy", busy, 1'b1);
        chk1("acc_mem_rd", mem_rd, !wr);
        chk1("acc_mem_wr", mem_wr, wr);
        chk4("acc_mem_x", mem_x, x);
        chk4("acc_mem_y", mem_y, y);
        chk1("acc_mem_din", mem_din, din);
        chk1("acc_sol_gnt", sol_gnt, !hwin);
        chk1("acc_host_gnt", host_gnt, hwin);
        chk1("acc_last_host", last_host, hwin);
        if (mode == 1) begin
            sol_x = ~sx;  sol_y = ~sy;  sol_wr = ~sw;  sol_din = ~sd;
            host_x = ~hx; host_y = ~hy; host_wr = ~hw; host_din = ~hd;
            #1;
            chk4("held_mem_x", mem_x, x);
            chk4("held_mem_y", mem_y, y);
            chk1("held_mem_din", mem_din, din);
            chk1("held_mem_wr", mem_wr, wr);
        end
        if (mode == 2) begin
            sol_req = 1'b0;
            host_req = 1'b0;
        end
        if (wr) m_mem[{y, x}] = din;
        else if (hwin) m_hdout = m_mem[{y, x}];
        else m_sdout = m_mem[{y, x}];
        m_last = hwin;

        @(negedge clk);
        chk1("rsp_busy", busy, 1'b1);
        chk1("rsp_sol_vld", sol_vld, !hwin);
        chk1("rsp_host_vld", host_vld, hwin);
        chk1("rsp_sol_gnt", sol_gnt, !hwin);
        chk1("rsp_host_gnt", host_gnt, hwin);
        chk1("rsp_mem_rd", mem_rd, 1'b0);
        chk1("rsp_mem_wr", mem_wr, 1'b0);
        chk1("rsp_sol_dout", sol_dout, m_sdout);
        chk1("rsp_host_dout", host_dout, m_hdout);

        @(negedge clk);
        chk1("idl_busy", busy, 1'b0);
        chk1("idl_sol_vld", sol_vld, 1'b0);
        chk1("idl_host_vld", host_vld, 1'b0);
        chk1("idl_sol_gnt", sol_gnt, 1'b0);
        chk1("idl_host_gnt", host_gnt, 1'b0);
        chk1("idl_mem_rd", mem_rd, 1'b0);
        chk1("idl_mem_wr", mem_wr, 1'b0);
        chk1("idl_last_host", last_host, m_last);
    endtask

    initial begin
        logic       sr, sw, sd, hr, hw, hd;
        logic [3:0] sx, sy, hx, hy;
        rst = 1'b0;
        load = 1'b1;
        sol_req = 0;  sol_wr = 0;  sol_x = 0;  sol_y = 0;  sol_din = 0;
        host_req = 0; host_wr = 0; host_x = 0; host_y = 0; host_din = 0;
        for (int i = 0; i < 8; i++) init_mem[i*32 +: 32] = $urandom;
        init_mem[{4'd5, 4'd3}] = 1'b1;
        m_mem = init_mem;
        m_last = 1'b0;
        m_sdout = 1'b0;
        m_hdout = 1'b0;

        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_sol_gnt", sol_gnt, 1'b0);
        chk1("rst_host_gnt", host_gnt, 1'b0);
        chk1("rst_sol_vld", sol_vld, 1'b0);
        chk1("rst_host_vld", host_vld, 1'b0);
        chk1("rst_sol_dout", sol_dout, 1'b0);
        chk1("rst_host_dout", host_dout, 1'b0);
        chk1("rst_mem_rd", mem_rd, 1'b0);
        chk1("rst_mem_wr", mem_wr, 1'b0);
        chk4("rst_mem_x", mem_x, 4'd0);
        chk4("rst_mem_y", mem_y, 4'd0);
        chk1("rst_mem_din", mem_din, 1'b0);
        chk1("rst_last_host", last_host, 1'b0);

        @(negedge clk);
        @(negedge clk);
        load = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk1("noreq_busy", busy, 1'b0);

        txn(1, 0, 4'd3, 4'd5, 0, 0, 0, 4'd0, 4'd0, 0, 0);
        txn(0, 0, 4'd0, 4'd0, 0, 1, 1, 4'd15, 4'd0, 1, 0);
        txn(1, 0, 4'd5, 4'd5, 0, 0, 0, 4'd0, 4'd0, 0, 1);
        txn(1, 1, 4'd0, 4'd15, 1, 0, 0, 4'd0, 4'd0, 0, 2);
        txn(0, 0, 4'd0, 4'd0, 0, 1, 0, 4'd3, 4'd7, 0, 2);

        sol_req = 1'b1; sol_wr = 1'b0; sol_x = 4'd7; sol_y = 4'd2;
        host_req = 1'b0;
        @(negedge clk);
        chk1("pre_rst_mem_rd", mem_rd, 1'b1);
        rst = 1'b0;
        #1;
        chk1("mid_rst_mem_rd", mem_rd, 1'b0);
        chk1("mid_rst_mem_wr", mem_wr, 1'b0);
        chk1("mid_rst_sol_gnt", sol_gnt, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk4("mid_rst_mem_x", mem_x, 4'd0);
        chk1("mid_rst_sol_dout", sol_dout, 1'b0);
        chk1("mid_rst_host_dout", host_dout, 1'b0);
        m_last = 1'b0;
        m_sdout = 1'b0;
        m_hdout = 1'b0;
        @(negedge clk);
        chk1("mid_rst_sol_vld", sol_vld, 1'b0);
        rst = 1'b1;
        txn(1, 0, 4'd7, 4'd2, 0, 0, 0, 4'd0, 4'd0, 0, 0);

        rst = 1'b0;
        @(negedge clk);
        m_last = 1'b0;
        m_sdout = 1'b0;
        m_hdout = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++)
            txn(1, 0, 4'(i), 4'd1, 0, 1, 0, 4'd2, 4'(i), 0, 0);

        for (int i = 0; i < 80; i++) begin
            sr = 1'($urandom); sw = 1'($urandom); sd = 1'($urandom);
            hr = 1'($urandom); hw = 1'($urandom); hd = 1'($urandom);
            sx = 4'($urandom); sy = 4'($urandom);
            hx = 4'($urandom); hy = 4'($urandom);
            if (!sr && !hr) sr = 1'b1;
            txn(sr, sw, sx, sy, sd, hr, hw, hx, hy, hd,
                int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
